math_cabs_sched: RTL and testbench
==================================

MATH_CABS_SCHED -- requirements
Module: math_cabs_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one magnitude pipeline (2..8).
REQ-002 SHALL have parameter LATENCY, default 14, clk cycles from cabs_dina/cabs_dinb to cabs_dout.
REQ-003 SHALL have clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have req_en  input  NUM_REQ  per-requester enable mask.
REQ-006 SHALL have req_valid  input  NUM_REQ  requester i has an operand pair.
REQ-007 SHALL have req_ready  output  NUM_REQ  requester i is granted this cycle.
REQ-008 SHALL have req_dina  input  32*NUM_REQ  real parts, requester i at bits [32i+31:32i], signed.
REQ-009 SHALL have req_dinb  input  32*NUM_REQ  imaginary parts, same packing, signed.
REQ-010 SHALL have cabs_dina  output  32  real operand to the shared magnitude pipeline.
REQ-011 SHALL have cabs_dinb  output  32  imaginary operand to the shared magnitude pipeline.
REQ-012 SHALL have cabs_dout  input  34  magnitude result from the shared pipeline.
REQ-013 SHALL have rsp_valid  output  NUM_REQ  one-hot, result for requester i on rsp_dout.
REQ-014 SHALL have rsp_dout  output  34  result data, shared by all requesters.
REQ-015 SHALL have inflight  output  5  number of accepted, not yet returned operations.
REQ-016 SHALL have busy  output  1  high when inflight is nonzero.

Function
REQ-017 SHALL assert at most one req_ready bit per cycle; the transfer (issue) occurs when req_valid[i] and req_ready[i] are both high.
REQ-018 SHALL compute req_ready combinationally from req_valid, req_en and the round-robin pointer, with no dependence on the response side (pipeline has no backpressure).
REQ-019 SHALL never grant requester i while req_en[i] is low; req_en changes take effect in the same cycle.
REQ-020 SHALL arbitrate round-robin: search starts at (last granted + 1) mod NUM_REQ; pointer updates only on an issue; pointer resets to NUM_REQ-1, so requester 0 wins first.
REQ-021 SHALL register the granted operands into cabs_dina/cabs_dinb one cycle after the issue, i.e. issue at T gives operands at T+1.
REQ-022 SHALL hold cabs_dina/cabs_dinb unchanged on cycles with no issue.
REQ-023 SHALL carry a (valid, id) tag through a LATENCY+1 stage shift register aligned so the tag for an issue at T meets cabs_dout at T+1+LATENCY.
REQ-024 SHALL register the response: rsp_dout equals cabs_dout sampled at T+1+LATENCY, and rsp_valid[id] is high for exactly one cycle at T+2+LATENCY (T+16 at default).
REQ-025 SHALL hold rsp_valid at zero and rsp_dout at its last value on cycles with no returning tag.
REQ-026 SHALL return results in issue order; back-to-back issues every cycle SHALL give back-to-back responses.
REQ-027 SHALL increment inflight on an issue, decrement it on a rsp_valid cycle, and leave it unchanged when both occur in the same cycle.
REQ-028 SHALL bound inflight at LATENCY+2 (16 at default), which needs no saturation logic.
REQ-029 SHALL drive busy as (inflight != 0), registered with inflight.

Reset
REQ-030 SHALL, while rst is high, force to zero: req_ready, all tag valid bits, rsp_valid, rsp_dout, cabs_dina, cabs_dinb and inflight; the round-robin pointer goes to NUM_REQ-1.
REQ-031 SHALL discard every operation in flight when reset is asserted mid-operation; stale cabs_dout data arriving after reset deassertion SHALL produce no rsp_valid.
REQ-032 SHALL accept a new issue on the first clk edge after rst deasserts.

Verification
REQ-033 SHALL cover single request: req_valid[2]=1, dina=3, dinb=-4, issue at T -> cabs_dina=3, cabs_dinb=-4 at T+1; rsp_valid=4'b0100 with model-correct rsp_dout (5, within pipeline precision) at T+16; inflight 1 over T+1..T+16, 0 after.
REQ-034 SHALL cover all four requesters valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; responses in the same order on 8 consecutive cycles; inflight peaks at 8.
REQ-035 SHALL cover masking: req_en=4'b1011 with all valid -> requester 2 never granted; grant order 0,1,3,0,1,3.
REQ-036 SHALL cover a simultaneous issue and response in one cycle -> inflight unchanged; no response lost or duplicated.
REQ-037 SHALL cover reset mid-operation: rst pulsed 5 cycles after 3 issues -> no rsp_valid for any of those three; inflight=0; a new issue right after reset returns exactly 16 cycles later.
REQ-038 SHALL cover a continuous stream at full rate (one issue every cycle for 100 cycles) -> inflight holds 16 in steady state and all 100 responses return in order.

Source files
------------

// File: rtl/math_cabs_sched.sv
// Round-robin scheduler sharing one fixed-latency complex-magnitude pipeline among NUM_REQ requesters.
// Issue->operands 1 cycle, issue->rsp_valid LATENCY+2 cycles; the pipeline never stalls, so grants ignore the response side.
module math_cabs_sched #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_en,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_dina,
  input  logic [32*NUM_REQ-1:0]  req_dinb,
  output logic [31:0]            cabs_dina,
  output logic [31:0]            cabs_dinb,
  input  logic [33:0]            cabs_dout,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [33:0]            rsp_dout,
  output logic [4:0]             inflight,
  output logic                   busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]             ptr;
  logic [NUM_REQ-1:0]        cand;
  logic [NUM_REQ-1:0]        grant;
  logic [PW-1:0]             gnt_id;
  logic [PW-1:0]             cidx;
  logic                      found;
  logic                      issue;
  logic                      rsp_any;
  logic [31:0]               sel_a;
  logic [31:0]               sel_b;
  logic [4:0]                inflight_nxt;
  logic [LATENCY:0]          tag_vld;
  logic [LATENCY:0][PW-1:0]  tag_id;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NUM_REQ;
    return PW'(s);
  endfunction

  assign cand = req_valid & req_en;

  // Search begins one past the last winner so every enabled requester is reached within NUM_REQ grants.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    cidx   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cidx = rr_idx(ptr, k);
      if (!found && cand[cidx]) begin
        found       = 1'b1;
        gnt_id      = cidx;
        grant[cidx] = 1'b1;
      end
    end
  end

  assign req_ready = rst ? '0 : grant;
  assign issue     = |req_ready;
  assign sel_a     = req_dina[32*gnt_id +: 32];
  assign sel_b     = req_dinb[32*gnt_id +: 32];
  assign rsp_any   = |rsp_valid;

  always_comb begin
    inflight_nxt = inflight;
    if (issue && !rsp_any)
      inflight_nxt = inflight + 5'd1;
    else if (!issue && rsp_any)
      inflight_nxt = inflight - 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= PW'(NUM_REQ - 1);
      cabs_dina <= '0;
      cabs_dinb <= '0;
      tag_vld   <= '0;
      tag_id    <= '0;
      rsp_valid <= '0;
      rsp_dout  <= '0;
      inflight  <= '0;
      busy      <= 1'b0;
    end else begin
      if (issue) begin
        ptr       <= gnt_id;
        cabs_dina <= sel_a;
        cabs_dinb <= sel_b;
      end
      // Stage 0 lines up with the operands; stage LATENCY lines up with cabs_dout.
      tag_vld <= {tag_vld[LATENCY-1:0], issue};
      tag_id  <= {tag_id[LATENCY-1:0], gnt_id};
      if (tag_vld[LATENCY]) begin
        rsp_valid <= NUM_REQ'(1) << tag_id[LATENCY];
        rsp_dout  <= cabs_dout;
      end else begin
        rsp_valid <= '0;
      end
      inflight <= inflight_nxt;
      busy     <= (inflight_nxt != 5'd0);
    end
  end

endmodule

// File: tb/tb_math_cabs_sched.sv
// Bench for math_cabs_sched: behavioural queue model with per-cycle compare plus directed literal checks.
module tb_math_cabs_sched;
  localparam int N = 4;
  localparam int L = 14;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   req_en, req_valid, req_ready, rsp_valid;
  logic [32*N-1:0] req_dina, req_dinb;
  logic [31:0]    cabs_dina, cabs_dinb;
  logic [33:0]    cabs_dout, rsp_dout;
  logic [4:0]     inflight;
  logic           busy;

  always #5 clk = ~clk;

  math_cabs_sched #(.NUM_REQ(N), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_valid(req_valid), .req_ready(req_ready),
    .req_dina(req_dina), .req_dinb(req_dinb), .cabs_dina(cabs_dina), .cabs_dinb(cabs_dinb),
    .cabs_dout(cabs_dout), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .inflight(inflight), .busy(busy)
  );

  function automatic logic [33:0] mag(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned s, r, t;
    sa = $signed(a);
    sb = $signed(b);
    s = longint'(sa * sa) + longint'(sb * sb);
    r = 0;
    for (int bit_i = 31; bit_i >= 0; bit_i--) begin
      t = r | (64'd1 << bit_i);
      if (t * t <= s) r = t;
    end
    return r[33:0];
  endfunction

  // External magnitude pipeline: result appears L cycles after the operands.
  logic [33:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= mag(cabs_dina, cabs_dinb);
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign cabs_dout = pipe[L-1];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int id; int due; logic [33:0] d; } rsp_t;
  rsp_t q[$];
  int mptr = N - 1;
  logic [31:0] exp_a = '0, exp_b = '0;
  logic [33:0] exp_dout = '0;
  int gnt_log[$], rsp_log[$], rsp_cyc[$];
  int peak = 0;

  always @(negedge clk) begin
    logic [N-1:0] er, ev;
    int gid;
    rsp_t e;
    if (rst) begin
      q.delete();
      mptr = N - 1;
      exp_a = '0; exp_b = '0; exp_dout = '0;
    end
    er = '0;
    gid = -1;
    if (!rst)
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (mptr + k) % N;
        if (gid < 0 && req_valid[i] && req_en[i]) gid = i;
      end
    if (gid >= 0) er[gid] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("cabs_dina", 64'(cabs_dina), 64'(exp_a));
    chk("cabs_dinb", 64'(cabs_dinb), 64'(exp_b));
    ev = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev[q[0].id] = 1'b1;
      exp_dout = q[0].d;
    end
    chk("inflight", 64'(inflight), 64'(q.size()));
    chk("busy", 64'(busy), 64'(q.size() != 0));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("rsp_dout", 64'(rsp_dout), 64'(exp_dout));
    if (ev != '0) void'(q.pop_front());
    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i]) begin rsp_log.push_back(i); rsp_cyc.push_back(cyc); end
      if (req_ready[i]) gnt_log.push_back(i);
    end
    if (int'(inflight) > peak) peak = int'(inflight);
    if (gid >= 0) begin
      e.id = gid;
      e.due = cyc + L + 2;
      e.d = mag(req_dina[32*gid +: 32], req_dinb[32*gid +: 32]);
      q.push_back(e);
      mptr = gid;
      exp_a = req_dina[32*gid +: 32];
      exp_b = req_dinb[32*gid +: 32];
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input int a, input int b);
    req_dina[32*i +: 32] = a;
    req_dinb[32*i +: 32] = b;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); rsp_log.delete(); rsp_cyc.delete(); peak = 0;
  endtask

  initial begin
    int ti;
    int ord4 [8];
    int ord3 [6];
    ord4 = '{0, 1, 2, 3, 0, 1, 2, 3};
    ord3 = '{0, 1, 3, 0, 1, 3};
    rst = 1'b1;
    req_en = '1;
    req_valid = '1;
    req_dina = '0;
    req_dinb = '0;
    step(2);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    req_valid = '0;
    rst = 1'b0;
    step(2);

    // Single request on requester 2: 3 - 4j.
    set_lane(2, 3, -4);
    req_valid = 4'b0100;
    step(1);
    req_valid = '0;
    chk("single_dina", 64'(cabs_dina), 64'd3);
    chk("single_dinb", 64'(cabs_dinb), 64'hFFFF_FFFC);
    chk("single_infl_t1", 64'(inflight), 64'd1);
    step(14);
    chk("single_early", 64'(rsp_valid), 64'd0);
    step(1);
    chk("single_rsp_valid", 64'(rsp_valid), 64'b0100);
    chk("single_rsp_dout", 64'(rsp_dout), 64'd5);
    chk("single_infl_t16", 64'(inflight), 64'd1);
    step(1);
    chk("single_infl_t17", 64'(inflight), 64'd0);
    chk("single_busy_t17", 64'(busy), 64'd0);

    // Reset pulse, then all four requesters for 8 cycles.
    rst = 1'b1; step(1); rst = 1'b0;
    for (int i = 0; i < N; i++) set_lane(i, 6 * (i + 1), -8 * (i + 1));
    clear_logs();
    req_valid = '1;
    step(8);
    req_valid = '0;
    step(20);
    chk("rr_gnt_count", 64'(gnt_log.size()), 64'd8);
    chk("rr_rsp_count", 64'(rsp_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < gnt_log.size() && k < rsp_log.size(); k++) begin
      chk("rr_gnt_order", 64'(gnt_log[k]), 64'(ord4[k]));
      chk("rr_rsp_order", 64'(rsp_log[k]), 64'(ord4[k]));
    end
    if (rsp_cyc.size() == 8) chk("rr_rsp_span", 64'(rsp_cyc[7] - rsp_cyc[0]), 64'd7);
    chk("rr_peak", 64'(peak), 64'd8);

    // Requester 2 masked off.
    clear_logs();
    req_en = 4'b1011;
    req_valid = '1;
    step(6);
    req_valid = '0;
    req_en = '1;
    step(20);
    chk("mask_gnt_count", 64'(gnt_log.size()), 64'd6);
    for (int k = 0; k < 6 && k < gnt_log.size(); k++)
      chk("mask_gnt_order", 64'(gnt_log[k]), 64'(ord3[k]));

    // Second issue lands in the same cycle as the first response.
    clear_logs();
    req_valid = 4'b0010;
    step(1);
    req_valid = '0;
    step(15);
    req_valid = 4'b0001;
    chk("overlap_rsp", 64'(rsp_valid), 64'b0010);
    step(1);
    req_valid = '0;
    chk("overlap_infl", 64'(inflight), 64'd1);
    step(20);
    chk("overlap_rsp_count", 64'(rsp_log.size()), 64'd2);
    if (rsp_log.size() == 2) begin
      chk("overlap_rsp0", 64'(rsp_log[0]), 64'd1);
      chk("overlap_rsp1", 64'(rsp_log[1]), 64'd0);
    end

    // Reset while three operations are in flight.
    clear_logs();
    req_valid = '1;
    step(3);
    req_valid = '0;
    chk("midrst_pre_infl", 64'(inflight), 64'd3);
    step(5);
    rst = 1'b1;
    step(1);
    chk("midrst_infl", 64'(inflight), 64'd0);
    chk("midrst_dina", 64'(cabs_dina), 64'd0);
    rst = 1'b0;
    req_valid = 4'b0100;
    ti = cyc;
    step(1);
    req_valid = '0;
    step(30);
    chk("midrst_rsp_count", 64'(rsp_log.size()), 64'd1);
    if (rsp_log.size() == 1) begin
      chk("midrst_rsp_id", 64'(rsp_log[0]), 64'd2);
      chk("midrst_rsp_lat", 64'(rsp_cyc[0] - ti), 64'd16);
    end

    // Full-rate stream of 100 issues; pointer now rests on requester 2.
    clear_logs();
    req_valid = '1;
    for (int j = 0; j < 100; j++) begin
      if (j == 50) chk("stream_infl_steady", 64'(inflight), 64'd16);
      for (int i = 0; i < N; i++)
        set_lane(i, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
      step(1);
    end
    req_valid = '0;
    step(25);
    chk("stream_rsp_count", 64'(rsp_log.size()), 64'd100);
    chk("stream_peak", 64'(peak), 64'd16);
    if (rsp_log.size() == 100) begin
      chk("stream_span", 64'(rsp_cyc[99] - rsp_cyc[0]), 64'd99);
      for (int k = 0; k < 100; k++)
        chk("stream_order", 64'(rsp_log[k]), 64'((3 + k) % 4));
    end
    chk("stream_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
